// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one word at a time, holds it for the decoder,
// and computes the next PC from jump/branch controls; misalignment or timeout faults.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        jumpLink,
  input  logic        jumpReg,
  input  logic        branchE,
  input  logic        branchNE,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [15:0] TLAST      = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state;
  logic [15:0] tcount;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic [31:0] jump_target;
  logic        branch_taken;

  assign pc_plus4     = pc + 32'd4;
  assign imem_addr    = pc;
  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign branch_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jump_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign branch_taken = (branchE & alu_zero) | (branchNE & ~alu_zero);

  // Register jump beats absolute jump beats taken branch beats sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jumpReg)
      next_pc = rs_data;
    else if (jump || jumpLink)
      next_pc = jump_target;
    else if (branch_taken)
      next_pc = pc_plus4 + branch_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      tcount      <= 16'd0;
      fault       <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          // An ack on the final allowed cycle still counts as a successful fetch.
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            tcount      <= 16'd0;
          end else if (TIMEOUT_EN && tcount == TLAST) begin
            state    <= FAULT;
            fault    <= 1'b1;
            imem_req <= 1'b0;
            tcount   <= 16'd0;
          end else begin
            tcount <= tcount + 16'd1;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              pc       <= next_pc;
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, random
// control sequences against a next-PC reference model, and fault/reset corners.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        jump = 1'b0, jumpLink = 1'b0, jumpReg = 1'b0, branchE = 1'b0, branchNE = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4;
  logic        fault;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .jump(jump), .jumpLink(jumpLink), .jumpReg(jumpReg), .branchE(branchE),
    .branchNE(branchNE), .alu_zero(alu_zero), .rs_data(rs_data),
    .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        j, jl, jr, be, bne, z;
    logic [31:0] rs;
    int          ackDelay;
    int          stallCycles;
    logic [31:0] expNext;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelPc;
  vec_t        vecs[14];

  function automatic vec_t mk(input logic [31:0] word, input logic [4:0] ctl, input logic z,
                              input logic [31:0] rs, input int ad, input int sc,
                              input logic [31:0] expNext);
    vec_t v;
    v.word = word;
    v.j = ctl[4]; v.jl = ctl[3]; v.jr = ctl[2]; v.be = ctl[1]; v.bne = ctl[0];
    v.z = z; v.rs = rs; v.ackDelay = ad; v.stallCycles = sc; v.expNext = expNext;
    return v;
  endfunction

  // Next address straight from the selection rules, using plain integer arithmetic.
  function automatic logic [31:0] refNext(input logic [31:0] curPc, input vec_t v);
    logic [31:0] seq;
    int          off;
    seq = curPc + 32'd4;
    off = $signed(v.word[15:0]);
    if (v.jr) return v.rs;
    if (v.j || v.jl) return (seq & 32'hF000_0000) | ({6'd0, v.word[25:0]} * 32'd4);
    if ((v.be && v.z) || (v.bne && !v.z)) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    jump = v.j; jumpLink = v.jl; jumpReg = v.jr; branchE = v.be; branchNE = v.bne;
    alu_zero = v.z; rs_data = v.rs;
  endtask

  task automatic clearControls();
    jump = 0; jumpLink = 0; jumpReg = 0; branchE = 0; branchNE = 0; alu_zero = 0; rs_data = 0;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkOutput("resetFault", fault, 0);
    checkOutput("resetReq", imem_req, 0);
    checkOutput("resetValid", instr_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    modelPc = 32'h0000_0000;
  endtask

  // Called in FETCH; returns in HOLD with the word latched.
  task automatic fetchWord(input logic [31:0] word, input int ackDelay);
    checkOutput("fetchReq", imem_req, 1);
    checkOutput("fetchAddr", imem_addr, modelPc);
    for (int i = 0; i < ackDelay; i++) begin
      tick();
      checkOutput("waitReq", imem_req, 1);
      checkOutput("waitAddr", imem_addr, modelPc);
      checkOutput("waitValid", instr_valid, 0);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    checkOutput("holdValid", instr_valid, 1);
    checkOutput("holdReq", imem_req, 0);
    checkOutput("holdInstr", instr, word);
    checkOutput("holdOpcode", {26'd0, opcode}, {26'd0, word[31:26]});
    checkOutput("holdFunct", {26'd0, funct}, {26'd0, word[5:0]});
    checkOutput("holdPc", pc, modelPc);
    checkOutput("holdPcPlus4", pc_plus4, modelPc + 32'd4);
  endtask

  task automatic runVector(input vec_t v);
    fetchWord(v.word, v.ackDelay);
    applyStimulus(v);
    for (int i = 0; i < v.stallCycles; i++) begin
      stall = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      checkOutput("stallValid", instr_valid, 1);
      checkOutput("stallReq", imem_req, 0);
      checkOutput("stallInstr", instr, v.word);
      checkOutput("stallPc", pc, modelPc);
    end
    stall = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    tick();
    clearControls();
    checkOutput("nextFault", fault, 0);
    checkOutput("nextReq", imem_req, 1);
    checkOutput("nextAddr", imem_addr, v.expNext);
    checkOutput("nextValid", instr_valid, 0);
    modelPc = v.expNext;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;

    vecs[0]  = mk(32'h2008_0005, 5'b00000, 1'b0, 32'h0,         0, 0, 32'h0000_0004);
    vecs[1]  = mk(32'h0800_0010, 5'b10000, 1'b0, 32'h0,         1, 0, 32'h0000_0040);
    vecs[2]  = mk(32'h1000_FFFE, 5'b00010, 1'b1, 32'h0,         0, 0, 32'h0000_003C);
    vecs[3]  = mk(32'h1000_FFFE, 5'b00010, 1'b0, 32'h0,         2, 0, 32'h0000_0040);
    vecs[4]  = mk(32'h1000_FFFE, 5'b00010, 1'b0, 32'h0,         0, 5, 32'h0000_0044);
    vecs[5]  = mk(32'h0000_0008, 5'b00100, 1'b0, 32'h1000_0000, 0, 0, 32'h1000_0000);
    vecs[6]  = mk(32'h0C00_0010, 5'b01000, 1'b0, 32'h0,         3, 1, 32'h1000_0040);
    vecs[7]  = mk(32'h1400_0003, 5'b00001, 1'b0, 32'h0,         0, 0, 32'h1000_0050);
    vecs[8]  = mk(32'h1400_0003, 5'b00001, 1'b1, 32'h0,         0, 2, 32'h1000_0054);
    vecs[9]  = mk(32'h0800_0010, 5'b10100, 1'b0, 32'h0000_0200, 0, 0, 32'h0000_0200);
    vecs[10] = mk(32'h0800_0020, 5'b10010, 1'b1, 32'h0,         1, 0, 32'h0000_0080);
    vecs[11] = mk(32'h1000_8000, 5'b00010, 1'b1, 32'h0,         0, 0, 32'hFFFE_0084);
    vecs[12] = mk(32'h0BFF_FFFF, 5'b10000, 1'b0, 32'h0,         0, 0, 32'hFFFF_FFFC);
    vecs[13] = mk(32'h0000_0000, 5'b00000, 1'b0, 32'h0,         0, 0, 32'h0000_0000);

    #12;
    checkOutput("rstReq", imem_req, 0);
    checkOutput("rstValid", instr_valid, 0);
    checkOutput("rstFault", fault, 0);
    checkOutput("rstPc", pc, 32'h0);
    checkOutput("rstInstr", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    modelPc = 32'h0;

    foreach (vecs[i]) runVector(vecs[i]);

    for (int n = 0; n < 40; n++) begin
      rv = mk($urandom, 5'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 32'h0);
      rv.expNext = refNext(modelPc, rv);
      runVector(rv);
    end

    // Misaligned register jump: sticky fault, nothing fetched until reset.
    fetchWord(32'h0000_0008, 1);
    jumpReg = 1'b1;
    rs_data = 32'h0000_0102;
    tick();
    clearControls();
    checkOutput("misFault", fault, 1);
    checkOutput("misReq", imem_req, 0);
    checkOutput("misValid", instr_valid, 0);
    checkOutput("misPc", pc, modelPc);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      tick();
      checkOutput("faultStickyFault", fault, 1);
      checkOutput("faultStickyReq", imem_req, 0);
      checkOutput("faultStickyPc", pc, modelPc);
    end
    imem_ack = 1'b0;

    // Sixteen FETCH cycles without ack.
    pulseReset();
    checkOutput("toStartReq", imem_req, 1);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("toBeforeFault", fault, 0);
    checkOutput("toBeforeReq", imem_req, 1);
    tick();
    checkOutput("toFault", fault, 1);
    checkOutput("toReq", imem_req, 0);

    // Ack on the sixteenth cycle wins over the timeout.
    pulseReset();
    for (int i = 0; i < 15; i++) tick();
    imem_ack = 1'b1;
    imem_rdata = 32'h2008_0005;
    tick();
    imem_ack = 1'b0;
    checkOutput("lateAckFault", fault, 0);
    checkOutput("lateAckValid", instr_valid, 1);
    checkOutput("lateAckInstr", instr, 32'h2008_0005);

    // Reset in the middle of a fetch; ack during and after reset is discarded.
    pulseReset();
    runVector(vecs[0]);
    runVector(vecs[1]);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReq", imem_req, 0);
    checkOutput("midRstPc", pc, 32'h0);
    checkOutput("midRstInstr", instr, 32'h0);
    checkOutput("midRstValid", instr_valid, 0);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    checkOutput("refetchReq", imem_req, 1);
    checkOutput("refetchAddr", imem_addr, 32'h0);
    checkOutput("refetchValid", instr_valid, 0);
    checkOutput("refetchInstr", instr, 32'h0);
    modelPc = 32'h0;
    fetchWord(32'h2008_0005, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
